// File: rtl/relogio_ajuste_ctrl.sv
// Timekeeping and adjust-mode controller for the 24 h clock: 1 Hz prescaler,
// hh:mm:ss counters and the button-driven NORMAL/AJ_SEG/AJ_MIN/AJ_HORA FSM.
module relogio_ajuste_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_modo,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [5:0] horas,
    output logic [1:0] modo_ajuste,
    output logic       tick_1hz
);

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int            IW         = $clog2(TIMEOUT_S + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        NORMAL  = 2'b00,
        AJ_SEG  = 2'b01,
        AJ_MIN  = 2'b10,
        AJ_HORA = 2'b11
    } estado_t;

    estado_t       estado;
    logic [PW-1:0] presc;
    logic [IW-1:0] idle;
    // [0],[1] synchronize the raw button, [2] holds the previous synchronized value
    logic [2:0]    modo_sr;
    logic [2:0]    inc_sr;
    logic [2:0]    dec_sr;
    logic          modo_p;
    logic          inc_p;
    logic          dec_p;
    logic          timeout;

    assign modo_p      = modo_sr[1] & ~modo_sr[2];
    assign inc_p       = inc_sr[1] & ~inc_sr[2];
    assign dec_p       = dec_sr[1] & ~dec_sr[2];
    assign tick_1hz    = (presc == PRESC_LAST);
    assign timeout     = tick_1hz && (idle == IDLE_LAST);
    assign modo_ajuste = estado;

    function automatic logic [5:0] passo(input logic [5:0] v, input logic [5:0] topo,
                                         input logic sobe);
        if (sobe) return (v == topo) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? topo : v - 6'd1;
    endfunction

    // NOTE: every register here is assigned with <= so all updates in one edge
    // see the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            estado   <= NORMAL;
            presc    <= '0;
            idle     <= '0;
            modo_sr  <= '0;
            inc_sr   <= '0;
            dec_sr   <= '0;
            segundos <= '0;
            minutos  <= '0;
            horas    <= '0;
        end else begin
            modo_sr <= {modo_sr[1:0], btn_modo};
            inc_sr  <= {inc_sr[1:0], btn_inc};
            dec_sr  <= {dec_sr[1:0], btn_dec};
            presc   <= tick_1hz ? '0 : presc + 1'b1;

            if (estado == NORMAL) begin
                if (tick_1hz) begin
                    segundos <= passo(segundos, 6'd59, 1'b1);
                    if (segundos == 6'd59) begin
                        minutos <= passo(minutos, 6'd59, 1'b1);
                        if (minutos == 6'd59) horas <= passo(horas, 6'd23, 1'b1);
                    end
                end
                if (modo_p) begin
                    estado <= AJ_SEG;
                    idle   <= '0;
                end
            end else if (modo_p) begin
                // A timeout in the same cycle as modo is a single exit, not exit+advance
                idle <= '0;
                if (timeout || estado == AJ_HORA) begin
                    estado <= NORMAL;
                    presc  <= '0;
                end else begin
                    estado <= estado_t'(estado + 2'd1);
                end
            end else if (inc_p != dec_p) begin
                idle <= '0;
                case (estado)
                    AJ_SEG:  segundos <= passo(segundos, 6'd59, inc_p);
                    AJ_MIN:  minutos  <= passo(minutos, 6'd59, inc_p);
                    default: horas    <= passo(horas, 6'd23, inc_p);
                endcase
            end else if (timeout) begin
                estado <= NORMAL;
                presc  <= '0;
                idle   <= '0;
            end else if (tick_1hz) begin
                idle <= idle + 1'b1;
            end
        end
    end

endmodule
